// File: rtl/rsa_apb_pkg.sv
// Shared definitions for the APB RSA controller: register map, bit positions and sequencer states.
package rsa_apb_pkg;

    localparam logic [11:0] OFS_DATA   = 12'h000;
    localparam logic [11:0] OFS_EXP    = 12'h100;
    localparam logic [11:0] OFS_MOD    = 12'h200;
    localparam logic [11:0] OFS_RESULT = 12'h300;
    localparam logic [11:0] OFS_CTRL   = 12'h400;
    localparam logic [11:0] OFS_STATUS = 12'h404;
    localparam logic [11:0] OFS_IRQ_EN = 12'h408;
    localparam logic [11:0] OFS_CYCLES = 12'h40C;

    localparam int CTRL_START_BIT       = 0;
    localparam int CTRL_CLR_DONE_BIT    = 1;
    localparam int STATUS_BUSY_BIT      = 0;
    localparam int STATUS_DONE_BIT      = 1;
    localparam int STATUS_ERR_START_BIT = 2;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_LOAD = 2'd1,
        SEQ_RUN  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/RSACypher.sv
// Modular exponentiation core: cypher = in_data ** in_exp mod in_mod, one exponent bit per cycle.
// ds (one cycle) latches the operands; ready stays high from completion until the next ds.
module RSACypher #(
    parameter int KEYSIZE = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ds,
    input  logic [KEYSIZE-1:0] in_data,
    input  logic [KEYSIZE-1:0] in_exp,
    input  logic [KEYSIZE-1:0] in_mod,
    output logic [KEYSIZE-1:0] cypher,
    output logic               ready
);
    localparam int CW = $clog2(KEYSIZE + 1);

    logic [KEYSIZE-1:0] base_r;
    logic [KEYSIZE-1:0] acc_r;
    logic [KEYSIZE-1:0] exp_r;
    logic [KEYSIZE-1:0] mod_r;
    logic [CW-1:0]      cnt_r;
    logic               run_r;

    function automatic logic [KEYSIZE-1:0] mod_mul(input logic [KEYSIZE-1:0] a,
                                                   input logic [KEYSIZE-1:0] b,
                                                   input logic [KEYSIZE-1:0] m);
        logic [2*KEYSIZE-1:0] p;
        p = {{KEYSIZE{1'b0}}, a} * {{KEYSIZE{1'b0}}, b};
        p = p % {{KEYSIZE{1'b0}}, m};
        return p[KEYSIZE-1:0];
    endfunction

    // Right-to-left square-and-multiply over all KEYSIZE exponent bits
    always_ff @(posedge clk) begin
        if (reset) begin
            base_r <= '0;
            acc_r  <= '0;
            exp_r  <= '0;
            mod_r  <= '0;
            cnt_r  <= '0;
            run_r  <= 1'b0;
            ready  <= 1'b0;
        end else if (ds) begin
            base_r <= mod_mul(in_data, KEYSIZE'(1), in_mod);
            acc_r  <= mod_mul(KEYSIZE'(1), KEYSIZE'(1), in_mod);
            exp_r  <= in_exp;
            mod_r  <= in_mod;
            cnt_r  <= '0;
            run_r  <= 1'b1;
            ready  <= 1'b0;
        end else if (run_r) begin
            if (exp_r[0]) begin
                acc_r <= mod_mul(acc_r, base_r, mod_r);
            end
            base_r <= mod_mul(base_r, base_r, mod_r);
            exp_r  <= exp_r >> 1;
            cnt_r  <= cnt_r + CW'(1);
            if (cnt_r == CW'(KEYSIZE - 1)) begin
                run_r <= 1'b0;
                ready <= 1'b1;
            end
        end
    end

    assign cypher = acc_r;

endmodule

// File: rtl/rsa_op_sequencer.sv
// Operation sequencer: IDLE/LOAD/RUN FSM, core start pulse, stale-ready masking, DONE/ERR_START flags.
// With RSA_APB_CYCLE_COUNT_EN defined it also keeps a saturating busy-cycle counter.
module rsa_op_sequencer
    import rsa_apb_pkg::*;
(
    input  logic        S_CLK,
    input  logic        S_RST,
    input  logic        start_req,
    input  logic        clr_req,
    input  logic        core_ready,
    output logic        busy,
    output logic        done,
    output logic        err_start,
    output logic        core_ds,
    output logic        capture
`ifdef RSA_APB_CYCLE_COUNT_EN
    ,
    output logic [31:0] cycles
`endif
);
    seq_state_e state_r, state_n;
    logic done_r, done_n;
    logic err_r, err_n;
    logic ds_r, ds_n;
    logic mask_r, mask_n;
    logic busy_s;
    logic capture_s;

    assign busy_s = (state_r != SEQ_IDLE);

    // State register
    always_ff @(posedge S_CLK) begin
        if (!S_RST) begin
            state_r <= SEQ_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Flag registers: sticky DONE/ERR_START, core start pulse and first-RUN-cycle mask
    always_ff @(posedge S_CLK) begin
        if (!S_RST) begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            ds_r   <= 1'b0;
            mask_r <= 1'b0;
        end else begin
            done_r <= done_n;
            err_r  <= err_n;
            ds_r   <= ds_n;
            mask_r <= mask_n;
        end
    end

    // Next state; a new START overrides CLR_DONE, completion overrides CLR_DONE
    always_comb begin
        state_n   = state_r;
        ds_n      = 1'b0;
        mask_n    = 1'b0;
        capture_s = 1'b0;
        if (clr_req) begin
            done_n = 1'b0;
        end else begin
            done_n = done_r;
        end
        if (start_req && busy_s) begin
            err_n = 1'b1;
        end else begin
            err_n = err_r;
        end
        case (state_r)
            SEQ_IDLE: begin
                if (start_req) begin
                    state_n = SEQ_LOAD;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                    ds_n    = 1'b1;
                end else begin
                    state_n = SEQ_IDLE;
                end
            end
            SEQ_LOAD: begin
                state_n = SEQ_RUN;
                mask_n  = 1'b1;
            end
            SEQ_RUN: begin
                if (core_ready && !mask_r) begin
                    capture_s = 1'b1;
                    done_n    = 1'b1;
                    state_n   = SEQ_IDLE;
                end else begin
                    state_n = SEQ_RUN;
                end
            end
            default: begin
                state_n = SEQ_IDLE;
            end
        endcase
    end

    assign busy      = busy_s;
    assign done      = done_r;
    assign err_start = err_r;
    assign core_ds   = ds_r;
    assign capture   = capture_s;

`ifdef RSA_APB_CYCLE_COUNT_EN
    logic [31:0] cyc_r, cyc_n;

    // Counter next value: cleared by an accepted START, counts LOAD/RUN cycles, saturates
    always_comb begin
        if (!busy_s && start_req) begin
            cyc_n = 32'd0;
        end else if (busy_s && (cyc_r != 32'hFFFF_FFFF)) begin
            cyc_n = cyc_r + 32'd1;
        end else begin
            cyc_n = cyc_r;
        end
    end

    // Counter register
    always_ff @(posedge S_CLK) begin
        if (!S_RST) begin
            cyc_r <= 32'd0;
        end else begin
            cyc_r <= cyc_n;
        end
    end

    assign cycles = cyc_r;
`endif

endmodule

// File: rtl/apb_rsa_ctrl.sv
// APB slave around RSACypher: operand/result register file, address decode with error responses, IRQ.
// Optional busy-cycle counter at 0x40C is enabled by defining RSA_APB_CYCLE_COUNT_EN.
module apb_rsa_ctrl
    import rsa_apb_pkg::*;
#(
    parameter int KEYSIZE = 128
) (
    input  logic        S_CLK,
    input  logic        S_RST,
    input  logic        S_PSEL,
    input  logic        S_PENABLE,
    input  logic [31:0] S_PADDR,
    input  logic        S_PWRITE,
    input  logic [31:0] S_PWDATA,
    output logic        S_PREADY,
    output logic        S_PSLVERR,
    output logic [31:0] S_PRDATA,
    output logic        IRQ
);
    localparam int NW = KEYSIZE / 32;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    logic [NW-1:0][31:0] data_r;
    logic [NW-1:0][31:0] exp_r;
    logic [NW-1:0][31:0] mod_r;
    logic [NW-1:0][31:0] result_r;
    logic                irq_en_r;
    logic                pready_r;
    logic                pslverr_r;
    logic [31:0]         prdata_r;

    logic                acc_s;
    logic [3:0]          region_s;
    logic [5:0]          word_s;
    logic [IW-1:0]       idx_s;
    logic                word_ok_s;
    logic                map_err_s;
    logic [31:0]         rdata_s;
    logic [31:0]         status_s;
    logic                ctrl_hit_s;
    logic                wr_data_s, wr_exp_s, wr_mod_s, wr_irq_en_s;
    logic                start_req_s, clr_req_s;
    logic                busy_s, done_s, err_start_s, core_ds_s, capture_s, core_ready_s;
    logic                core_rst_s;
    logic [KEYSIZE-1:0]  core_data_s, core_exp_s, core_mod_s, core_result_s;
    logic                unused_s;
`ifdef RSA_APB_CYCLE_COUNT_EN
    logic [31:0]         cycles_s;
`endif

    assign acc_s     = S_PSEL & S_PENABLE & ~pready_r;
    assign region_s  = S_PADDR[11:8];
    assign word_s    = S_PADDR[7:2];
    assign idx_s     = S_PADDR[2 +: IW];
    assign word_ok_s = ({1'b0, word_s} < 7'(NW)) && (S_PADDR[1:0] == 2'b00);
    assign unused_s  = ^S_PADDR[31:12];

    // STATUS word assembly
    always_comb begin
        status_s                       = 32'd0;
        status_s[STATUS_BUSY_BIT]      = busy_s;
        status_s[STATUS_DONE_BIT]      = done_s;
        status_s[STATUS_ERR_START_BIT] = err_start_s;
    end

    // Address decode: read data, error response and legal write strobes
    always_comb begin
        rdata_s     = 32'd0;
        map_err_s   = 1'b0;
        ctrl_hit_s  = 1'b0;
        wr_data_s   = 1'b0;
        wr_exp_s    = 1'b0;
        wr_mod_s    = 1'b0;
        wr_irq_en_s = 1'b0;
        case (region_s)
            OFS_DATA[11:8]: begin
                if (!word_ok_s || (S_PWRITE && busy_s)) begin
                    map_err_s = 1'b1;
                end else begin
                    rdata_s   = data_r[idx_s];
                    wr_data_s = S_PWRITE;
                end
            end
            OFS_EXP[11:8]: begin
                if (!word_ok_s || (S_PWRITE && busy_s)) begin
                    map_err_s = 1'b1;
                end else begin
                    rdata_s  = exp_r[idx_s];
                    wr_exp_s = S_PWRITE;
                end
            end
            OFS_MOD[11:8]: begin
                if (!word_ok_s || (S_PWRITE && busy_s)) begin
                    map_err_s = 1'b1;
                end else begin
                    rdata_s  = mod_r[idx_s];
                    wr_mod_s = S_PWRITE;
                end
            end
            OFS_RESULT[11:8]: begin
                if (!word_ok_s || S_PWRITE) begin
                    map_err_s = 1'b1;
                end else begin
                    rdata_s = result_r[idx_s];
                end
            end
            OFS_CTRL[11:8]: begin
                case (S_PADDR[7:0])
                    OFS_CTRL[7:0]: begin
                        ctrl_hit_s = 1'b1;
                        if (S_PWRITE && S_PWDATA[CTRL_START_BIT] && busy_s) begin
                            map_err_s = 1'b1;
                        end else begin
                            map_err_s = 1'b0;
                        end
                    end
                    OFS_STATUS[7:0]: begin
                        if (S_PWRITE) begin
                            map_err_s = 1'b1;
                        end else begin
                            rdata_s = status_s;
                        end
                    end
                    OFS_IRQ_EN[7:0]: begin
                        rdata_s     = {31'd0, irq_en_r};
                        wr_irq_en_s = S_PWRITE;
                    end
`ifdef RSA_APB_CYCLE_COUNT_EN
                    OFS_CYCLES[7:0]: begin
                        if (S_PWRITE) begin
                            map_err_s = 1'b1;
                        end else begin
                            rdata_s = cycles_s;
                        end
                    end
`else
                    OFS_CYCLES[7:0]: begin
                        map_err_s = 1'b1;
                    end
`endif
                    default: begin
                        map_err_s = 1'b1;
                    end
                endcase
            end
            default: begin
                map_err_s = 1'b1;
            end
        endcase
    end

    // START while busy is still forwarded so the sequencer can flag ERR_START
    assign start_req_s = acc_s & S_PWRITE & ctrl_hit_s & S_PWDATA[CTRL_START_BIT];
    assign clr_req_s   = acc_s & S_PWRITE & ctrl_hit_s & S_PWDATA[CTRL_CLR_DONE_BIT] & ~map_err_s;

    // Register file writes and result capture
    always_ff @(posedge S_CLK) begin
        if (!S_RST) begin
            data_r   <= '0;
            exp_r    <= '0;
            mod_r    <= '0;
            result_r <= '0;
            irq_en_r <= 1'b0;
        end else begin
            if (acc_s && wr_data_s) begin
                data_r[idx_s] <= S_PWDATA;
            end
            if (acc_s && wr_exp_s) begin
                exp_r[idx_s] <= S_PWDATA;
            end
            if (acc_s && wr_mod_s) begin
                mod_r[idx_s] <= S_PWDATA;
            end
            if (acc_s && wr_irq_en_s) begin
                irq_en_r <= S_PWDATA[0];
            end
            if (capture_s) begin
                result_r <= core_result_s;
            end
        end
    end

    // APB response: one-cycle PREADY with data/error, zero otherwise
    always_ff @(posedge S_CLK) begin
        if (!S_RST) begin
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= 32'd0;
        end else if (acc_s) begin
            pready_r  <= 1'b1;
            pslverr_r <= map_err_s;
            prdata_r  <= map_err_s ? 32'd0 : rdata_s;
        end else begin
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= 32'd0;
        end
    end

    assign S_PREADY  = pready_r;
    assign S_PSLVERR = pslverr_r;
    assign S_PRDATA  = prdata_r;
    assign IRQ       = done_s & irq_en_r;

    assign core_rst_s  = ~S_RST;
    assign core_data_s = data_r;
    assign core_exp_s  = exp_r;
    assign core_mod_s  = mod_r;

    rsa_op_sequencer u_seq (
        .S_CLK      (S_CLK),
        .S_RST      (S_RST),
        .start_req  (start_req_s),
        .clr_req    (clr_req_s),
        .core_ready (core_ready_s),
        .busy       (busy_s),
        .done       (done_s),
        .err_start  (err_start_s),
        .core_ds    (core_ds_s),
        .capture    (capture_s)
`ifdef RSA_APB_CYCLE_COUNT_EN
        ,
        .cycles     (cycles_s)
`endif
    );

    RSACypher #(
        .KEYSIZE (KEYSIZE)
    ) u_core (
        .clk     (S_CLK),
        .reset   (core_rst_s),
        .ds      (core_ds_s),
        .in_data (core_data_s),
        .in_exp  (core_exp_s),
        .in_mod  (core_mod_s),
        .cypher  (core_result_s),
        .ready   (core_ready_s)
    );

endmodule

// File: tb/tb_apb_rsa_ctrl.sv
// Self-checking bench for apb_rsa_ctrl: register-map vector table, directed sequences, random modexp vs model.
module tb_apb_rsa_ctrl;
    localparam int KEYSIZE = 128;
    localparam int NW      = KEYSIZE / 32;

    logic        S_CLK, S_RST, S_PSEL, S_PENABLE, S_PWRITE;
    logic [31:0] S_PADDR, S_PWDATA;
    logic        S_PREADY, S_PSLVERR, IRQ;
    logic [31:0] S_PRDATA;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_acc_cyc = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        string       name;
    } vec_t;

    vec_t tbl[$];

    apb_rsa_ctrl #(.KEYSIZE(KEYSIZE)) dut (
        .S_CLK     (S_CLK),
        .S_RST     (S_RST),
        .S_PSEL    (S_PSEL),
        .S_PENABLE (S_PENABLE),
        .S_PADDR   (S_PADDR),
        .S_PWRITE  (S_PWRITE),
        .S_PWDATA  (S_PWDATA),
        .S_PREADY  (S_PREADY),
        .S_PSLVERR (S_PSLVERR),
        .S_PRDATA  (S_PRDATA),
        .IRQ       (IRQ)
    );

    initial S_CLK = 1'b0;
    always #5 S_CLK = ~S_CLK;
    always @(posedge S_CLK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Plain left-to-right square-and-multiply
    function automatic logic [KEYSIZE-1:0] ref_modexp(input logic [KEYSIZE-1:0] b,
                                                      input logic [KEYSIZE-1:0] e,
                                                      input logic [KEYSIZE-1:0] m);
        logic [2*KEYSIZE-1:0] r, bb, mm;
        mm = {{KEYSIZE{1'b0}}, m};
        bb = {{KEYSIZE{1'b0}}, b} % mm;
        r  = 1 % mm;
        for (int i = KEYSIZE - 1; i >= 0; i--) begin
            r = (r * r) % mm;
            if (e[i]) r = (r * bb) % mm;
        end
        return r[KEYSIZE-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        S_PSEL = 1'b1; S_PWRITE = wr; S_PADDR = addr; S_PWDATA = wdata; S_PENABLE = 1'b0;
        @(posedge S_CLK); #1;
        S_PENABLE = 1'b1;
        last_acc_cyc = cyc;
        for (int k = 0; k < 8; k++) begin
            @(posedge S_CLK); #1;
            if (S_PREADY) break;
        end
        if (!S_PREADY) begin
            n_cmp++; n_fail++;
            $display("FAIL apb_timeout: no PREADY for addr 0x%03h", addr);
        end
        rdata = S_PRDATA;
        err   = S_PSLVERR;
        S_PSEL = 1'b0; S_PENABLE = 1'b0;
        @(posedge S_CLK); #1;
        check("pready_one_cycle", {31'd0, S_PREADY}, 32'd0);
        check("prdata_idle_zero", S_PRDATA, 32'd0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic eerr, input string nm);
        logic [31:0] d; logic e;
        apb(1'b0, a, 32'd0, d, e);
        check({nm, "_err"}, {31'd0, e}, {31'd0, eerr});
        check(nm, d, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] dt, input logic eerr, input string nm);
        logic [31:0] d; logic e;
        apb(1'b1, a, dt, d, e);
        check({nm, "_err"}, {31'd0, e}, {31'd0, eerr});
        if (eerr) check({nm, "_rdata"}, d, 32'd0);
    endtask

    task automatic set_operands(input logic [KEYSIZE-1:0] b, input logic [KEYSIZE-1:0] e,
                                input logic [KEYSIZE-1:0] m);
        for (int w = 0; w < NW; w++) begin
            wr(32'h000 + 32'(4 * w), b[32*w +: 32], 1'b0, "wr_data");
            wr(32'h100 + 32'(4 * w), e[32*w +: 32], 1'b0, "wr_exp");
            wr(32'h200 + 32'(4 * w), m[32*w +: 32], 1'b0, "wr_mod");
        end
    endtask

    task automatic wait_irq(input int budget, output int t_done);
        t_done = -1;
        for (int k = 0; k < budget; k++) begin
            @(posedge S_CLK); #1;
            if (IRQ) begin
                t_done = cyc;
                break;
            end
        end
        if (t_done < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: IRQ not seen within %0d cycles", budget);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          t_start, t_done;
        logic [KEYSIZE-1:0] rb, re, rm, rexp;

        S_RST = 1'b0; S_PSEL = 1'b0; S_PENABLE = 1'b0; S_PWRITE = 1'b0;
        S_PADDR = 32'd0; S_PWDATA = 32'd0;
        repeat (3) @(posedge S_CLK);
        #1;
        check("rst_pready",  {31'd0, S_PREADY},  32'd0);
        check("rst_pslverr", {31'd0, S_PSLVERR}, 32'd0);
        check("rst_prdata",  S_PRDATA,           32'd0);
        check("rst_irq",     {31'd0, IRQ},       32'd0);
        S_RST = 1'b1;
        @(posedge S_CLK); #1;

        // Register map vectors
        tbl.push_back('{1'b0, 32'h404, 32'd0, 32'd0, 1'b0, "status_rst"});
        tbl.push_back('{1'b0, 32'h300, 32'd0, 32'd0, 1'b0, "result0_rst"});
        tbl.push_back('{1'b0, 32'h408, 32'd0, 32'd0, 1'b0, "irqen_rst"});
        tbl.push_back('{1'b0, 32'h400, 32'd0, 32'd0, 1'b0, "ctrl_reads0"});
        tbl.push_back('{1'b0, 32'h000, 32'd0, 32'd0, 1'b0, "data0_rst"});
        tbl.push_back('{1'b0, 32'h010, 32'd0, 32'd0, 1'b1, "data_w4_oob"});
        tbl.push_back('{1'b0, 32'h310, 32'd0, 32'd0, 1'b1, "result_w4_oob"});
        tbl.push_back('{1'b0, 32'h500, 32'd0, 32'd0, 1'b1, "unmapped_500"});
        tbl.push_back('{1'b0, 32'h410, 32'd0, 32'd0, 1'b1, "unmapped_410"});
        tbl.push_back('{1'b1, 32'h300, 32'h1, 32'd0, 1'b1, "wr_result"});
        tbl.push_back('{1'b1, 32'h404, 32'h1, 32'd0, 1'b1, "wr_status"});
        tbl.push_back('{1'b1, 32'h408, 32'h1, 32'd0, 1'b0, "wr_irqen"});
        tbl.push_back('{1'b0, 32'h408, 32'd0, 32'd1, 1'b0, "irqen_rb"});
        tbl.push_back('{1'b1, 32'h408, 32'h0, 32'd0, 1'b0, "wr_irqen0"});
        tbl.push_back('{1'b1, 32'h000, 32'hDEADBEEF, 32'd0, 1'b0, "wr_data0"});
        tbl.push_back('{1'b0, 32'h000, 32'd0, 32'hDEADBEEF, 1'b0, "data0_rb"});
        tbl.push_back('{1'b1, 32'h20C, 32'h12345678, 32'd0, 1'b0, "wr_mod3"});
        tbl.push_back('{1'b0, 32'h20C, 32'd0, 32'h12345678, 1'b0, "mod3_rb"});
        tbl.push_back('{1'b1, 32'h104, 32'hCAFEF00D, 32'd0, 1'b0, "wr_exp1"});
        tbl.push_back('{1'b0, 32'h104, 32'd0, 32'hCAFEF00D, 1'b0, "exp1_rb"});
        tbl.push_back('{1'b0, 32'h30C, 32'd0, 32'd0, 1'b0, "result3_rst"});
`ifdef RSA_APB_CYCLE_COUNT_EN
        tbl.push_back('{1'b0, 32'h40C, 32'd0, 32'd0, 1'b0, "cycles_rst"});
`else
        tbl.push_back('{1'b0, 32'h40C, 32'd0, 32'd0, 1'b1, "cycles_absent"});
`endif
        foreach (tbl[i]) begin
            apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, d, e);
            check({tbl[i].name, "_err"}, {31'd0, e}, {31'd0, tbl[i].err});
            if (!tbl[i].wr || tbl[i].err) check({tbl[i].name, "_data"}, d, tbl[i].rdata);
        end

        // 4^13 mod 497 with illegal accesses while busy
        set_operands(128'd4, 128'd13, 128'd497);
        wr(32'h408, 32'd1, 1'b0, "irqen_on");
        wr(32'h400, 32'd1, 1'b0, "start1");
        t_start = last_acc_cyc;
        rd(32'h404, 32'd1, 1'b0, "status_busy");
        check("irq_while_busy", {31'd0, IRQ}, 32'd0);
        wr(32'h000, 32'd5, 1'b1, "wr_data_busy");
        wr(32'h400, 32'd1, 1'b1, "start_busy");
        rd(32'h404, 32'd5, 1'b0, "status_err_start");
        rd(32'h000, 32'd4, 1'b0, "data0_kept");
        wait_irq(2000, t_done);
        rd(32'h404, 32'd6, 1'b0, "status_done");
        check("irq_done", {31'd0, IRQ}, 32'd1);
        rd(32'h300, 32'h1BD, 1'b0, "result0_1bd");
        rd(32'h304, 32'd0, 1'b0, "result1");
        rd(32'h308, 32'd0, 1'b0, "result2");
        rd(32'h30C, 32'd0, 1'b0, "result3");
`ifdef RSA_APB_CYCLE_COUNT_EN
        rd(32'h40C, 32'(t_done - t_start - 1), 1'b0, "cycles_count");
        rd(32'h40C, 32'(t_done - t_start - 1), 1'b0, "cycles_frozen");
`else
        rd(32'h40C, 32'd0, 1'b1, "cycles_unmapped");
`endif

        // CLR_DONE and error responses
        wr(32'h400, 32'd2, 1'b0, "clr_done");
        rd(32'h404, 32'd4, 1'b0, "status_cleared");
        check("irq_cleared", {31'd0, IRQ}, 32'd0);
        rd(32'h300, 32'h1BD, 1'b0, "result_kept");
        rd(32'h500, 32'd0, 1'b1, "rd_500");
        wr(32'h300, 32'd7, 1'b1, "wr_300");

        // Reset in the middle of RUN
        set_operands(128'd3, 128'd5, 128'd7);
        wr(32'h400, 32'd1, 1'b0, "start2");
        repeat (20) @(posedge S_CLK);
        #1;
        S_RST = 1'b0;
        @(posedge S_CLK); #1;
        S_RST = 1'b1;
        check("irq_after_rst", {31'd0, IRQ}, 32'd0);
        rd(32'h404, 32'd0, 1'b0, "status_after_rst");
        rd(32'h000, 32'd0, 1'b0, "data0_after_rst");
        rd(32'h200, 32'd0, 1'b0, "mod0_after_rst");
        rd(32'h300, 32'd0, 1'b0, "result0_after_rst");
        rd(32'h408, 32'd0, 1'b0, "irqen_after_rst");
        set_operands(128'd3, 128'd5, 128'd7);
        wr(32'h408, 32'd1, 1'b0, "irqen_on2");
        wr(32'h400, 32'd1, 1'b0, "start3");
        wait_irq(2000, t_done);
        rd(32'h300, 32'd5, 1'b0, "result0_5");

        // Random operands against the model; START+CLR_DONE together must start
        for (int it = 0; it < 3; it++) begin
            rb = {$urandom(), $urandom(), $urandom(), $urandom()};
            re = {$urandom(), $urandom(), $urandom(), $urandom()};
            rm = {$urandom(), $urandom(), $urandom(), $urandom()} | 128'd1;
            rexp = ref_modexp(rb, re, rm);
            set_operands(rb, re, rm);
            wr(32'h400, 32'd3, 1'b0, "start_clr");
            rd(32'h404, 32'd1, 1'b0, "status_restart");
            wait_irq(2000, t_done);
            for (int w = 0; w < NW; w++) begin
                rd(32'h300 + 32'(4 * w), rexp[32*w +: 32], 1'b0, "rand_result");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
